// File: rtl/segments_pkg.sv
// Shared constants and types for the two-digit 7-segment decoder.
package segments_pkg;

  // Segment order a..g, MSB = a
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int unsigned MAX_VALUE = 59;
  localparam int unsigned MAX_TENS  = MAX_VALUE / 10;

  typedef enum logic {
    S_WAIT,
    S_OUT
  } state_t;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational 7-segment code to BCD digit decoder with legality flag.
module seg_digit_decode
  import segments_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (code)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/segments_decoder.sv
// Debounced two-digit 7-segment bus decoder with valid/ready output.
// Optional stall counter output enabled by SEGMENTS_DECODER_STALL_CNT_EN.
module segments_decoder
  import segments_pkg::*;
#(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned WIDTH1        = 14,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH1-1:0] seg_in,
  output logic [WIDTH-1:0]  out_value,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef SEGMENTS_DECODER_STALL_CNT_EN
  ,
  output logic [7:0]        stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HALF  = WIDTH1 / 2;

  logic [WIDTH1-1:0] seg_q;
  logic [WIDTH1-1:0] last_rep, last_rep_d;
  logic [CNT_W-1:0]  stab_cnt, stab_cnt_d;
  logic              stable;
  state_t            state, state_d;

  logic [WIDTH-1:0]  out_value_d;
  logic              out_err_d;
  logic              out_valid_d;

  logic [3:0]        tens, units;
  logic              tens_ok, units_ok;
  logic              legal;
  logic [WIDTH-1:0]  value_c;

  // Stability counter: clears on any change, saturates at STABLE_CYCLES
  always_comb begin
    stab_cnt_d = stab_cnt;
    if (seg_in != seg_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
      stab_cnt_d = stab_cnt + CNT_W'(1);
    end
  end

  assign stable = (stab_cnt == CNT_W'(STABLE_CYCLES));

  seg_digit_decode u_tens (
    .code  (seg_q[WIDTH1-1:HALF]),
    .digit (tens),
    .legal (tens_ok)
  );

  seg_digit_decode u_units (
    .code  (seg_q[HALF-1:0]),
    .digit (units),
    .legal (units_ok)
  );

  assign legal   = tens_ok && units_ok && (tens <= 4'(MAX_TENS));
  assign value_c = legal ? (WIDTH'(tens) * WIDTH'(10) + WIDTH'(units)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '0;
      stab_cnt  <= '0;
      last_rep  <= '0;
      state     <= S_WAIT;
      out_value <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      seg_q     <= seg_in;
      stab_cnt  <= stab_cnt_d;
      last_rep  <= last_rep_d;
      state     <= state_d;
      out_value <= out_value_d;
      out_err   <= out_err_d;
      out_valid <= out_valid_d;
    end
  end

  // Report FSM: a stable, non-blank pattern differing from the last report is offered once
  always_comb begin
    state_d     = state;
    last_rep_d  = last_rep;
    out_value_d = out_value;
    out_err_d   = out_err;
    out_valid_d = out_valid;
    case (state)
      S_WAIT: begin
        if (stable) begin
          if (seg_q == '0) begin
            last_rep_d = '0;
          end else if (seg_q != last_rep) begin
            out_value_d = value_c;
            out_err_d   = !legal;
            out_valid_d = 1'b1;
            last_rep_d  = seg_q;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
    endcase
  end

  assign busy = (state == S_OUT);

`ifdef SEGMENTS_DECODER_STALL_CNT_EN
  logic stall_inc_c;

  // A fresh stable update arrived while the consumer was holding us in S_OUT
  assign stall_inc_c = (state == S_OUT) && !stable &&
                       (stab_cnt_d == CNT_W'(STABLE_CYCLES)) &&
                       (seg_q != last_rep) && (seg_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
    end else if (stall_inc_c && (stall_cnt != 8'd255)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule
